// File: rtl/func_pkg.sv
// Shared types and elaboration helpers for the func_param root-combination unit.
package func_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROOT1,
    S_ADD,
    S_ROOT2,
    S_DONE
  } state_t;

  function automatic bit is_legal_w(input int w);
    return (w >= 4) && (w <= 16) && ((w % 2) == 0);
  endfunction

  // Cube-root digits needed to cover a (w+1)-bit operand.
  function automatic int cbrt_digits(input int w);
    return (w + 3) / 3;
  endfunction

endpackage

// File: rtl/func_isqrt.sv
// Iterative floor square root: two input bits consumed, one root bit produced per cycle.
module func_isqrt #(
  parameter int IW = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [IW-1:0]   i_x,
  output logic            o_done,
  output logic [IW/2-1:0] o_root
);
  localparam int RW = IW / 2;
  localparam int CW = $clog2(RW);

  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_x;
  logic [RW:0]   r_rem;
  logic [RW-1:0] r_root;

  logic [RW+2:0] w_rs;
  logic [RW+2:0] w_tr;
  logic          w_ge;

  always_comb begin
    w_rs = {r_rem, r_x[IW-1 -: 2]};
    w_tr = {1'b0, r_root, 2'b01};
    w_ge = (w_rs >= w_tr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_rem  <= '0;
      r_root <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(RW - 1);
        r_x    <= i_x;
        r_rem  <= '0;
        r_root <= '0;
      end else if (r_busy) begin
        r_x    <= r_x << 2;
        r_rem  <= w_ge ? (RW+1)'(w_rs - w_tr) : (RW+1)'(w_rs);
        r_root <= {r_root[RW-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_root = r_root;

endmodule

// File: rtl/func_param.sv
// func_param: mode 0 -> isqrt(a + icbrt(b)), mode 1 -> icbrt(a + isqrt(b)).
// One shared bit-serial square-root unit; the cube root iterates inline.
module func_param
  import func_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [W-1:0] a_bi,
  input  logic [W-1:0] b_bi,
  output logic         busy_o,
  output logic         done_o,
  output logic [W/2:0] y_bo
);
  localparam int YW = W / 2 + 1;
  localparam int SW = W + 1;
  localparam int IW = W + 2;
  localparam int CN = cbrt_digits(W);
  localparam int XW = 3 * CN;
  localparam int TW = 2 * CN + 4;
  localparam int GW = XW + TW;

  if (!is_legal_w(W)) begin : g_bad_w
    $error("func_param: W must be even and within 4..16");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_mode;
  logic [W-1:0]  r_a;
  logic [XW-1:0] r_cx;
  logic [CN-1:0] r_cy;
  logic [3:0]    r_cnt;
  logic [YW-1:0] r_r1;
  logic [YW-1:0] r_y;

  logic [5:0]    w_sh;
  logic [CN:0]   w_y2;
  logic [TW-1:0] w_term;
  logic [XW-1:0] w_xs;
  logic [XW-1:0] w_tsh;
  logic          w_ge;
  logic [XW-1:0] w_cx_nxt;
  logic [CN-1:0] w_cy_nxt;
  logic [YW-1:0] w_root1;
  logic [SW-1:0] w_sum;
  logic          w_sq_start;
  logic          w_sq_done;
  logic [IW-1:0] w_sq_x;
  logic [YW-1:0] w_sq_root;

  func_isqrt #(.IW(IW)) u_isqrt (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_start (w_sq_start),
    .i_x     (w_sq_x),
    .o_done  (w_sq_done),
    .o_root  (w_sq_root)
  );

  // Cube-root digit step: remainder is compared pre-shifted so the trial term stays narrow.
  always_comb begin
    w_sh     = 6'(r_cnt) * 6'd3;
    w_y2     = {r_cy, 1'b0};
    w_term   = TW'(3) * TW'(w_y2) * (TW'(w_y2) + TW'(1)) + TW'(1);
    w_xs     = r_cx >> w_sh;
    w_tsh    = XW'(w_term) << w_sh;
    w_ge     = (GW'(w_xs) >= GW'(w_term));
    w_cx_nxt = w_ge ? (r_cx - w_tsh) : r_cx;
    w_cy_nxt = {r_cy[CN-2:0], w_ge};
  end

  assign w_root1 = r_mode ? r_r1 : YW'(r_cy);
  assign w_sum   = SW'(r_a) + SW'(w_root1);

  always_comb begin
    w_state_nxt = r_state;
    w_sq_start  = 1'b0;
    w_sq_x      = IW'(w_sum);
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_ROOT1;
          w_sq_start  = mode_i;
          w_sq_x      = IW'(b_bi);
        end
      end
      S_ROOT1: begin
        busy_o = 1'b1;
        if (r_mode ? w_sq_done : (r_cnt == '0)) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        busy_o      = 1'b1;
        w_state_nxt = S_ROOT2;
        w_sq_start  = !r_mode;
      end
      S_ROOT2: begin
        busy_o = 1'b1;
        if (r_mode ? (r_cnt == '0) : w_sq_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_a     <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_cnt   <= '0;
      r_r1    <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode <= mode_i;
            r_a    <= a_bi;
            r_cx   <= XW'(b_bi);
            r_cy   <= '0;
            r_cnt  <= 4'(CN - 1);
            r_r1   <= '0;
          end
        end
        S_ROOT1: begin
          if (!r_mode) begin
            r_cx  <= w_cx_nxt;
            r_cy  <= w_cy_nxt;
            r_cnt <= r_cnt - 4'd1;
          end else if (w_sq_done) begin
            r_r1 <= w_sq_root;
          end
        end
        S_ADD: begin
          if (r_mode) begin
            r_cx  <= XW'(w_sum);
            r_cy  <= '0;
            r_cnt <= 4'(CN - 1);
          end
        end
        S_ROOT2: begin
          if (r_mode) begin
            r_cx  <= w_cx_nxt;
            r_cy  <= w_cy_nxt;
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == '0) r_y <= YW'(w_cy_nxt);
          end else if (w_sq_done) begin
            r_y <= w_sq_root;
          end
        end
        default: ;
      endcase
    end
  end

  assign y_bo = r_y;

endmodule

// File: tb/tb_func_param.sv
// Scoreboard bench for func_param at W=8 and W=16 against a plain-arithmetic root model.
module tb_func_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b0, start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [4:0] y8;

  logic        rst16 = 1'b0, start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [8:0]  y16;

  func_param #(.W(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .start_i(start8), .mode_i(mode8),
    .a_bi(a8), .b_bi(b8), .busy_o(busy8), .done_o(done8), .y_bo(y8)
  );

  func_param #(.W(16)) dut16 (
    .clk_i(clk), .rst_i(rst16), .start_i(start16), .mode_i(mode16),
    .a_bi(a16), .b_bi(b16), .busy_o(busy16), .done_o(done16), .y_bo(y16)
  );

  localparam int LIM8  = 4 * 8 + 8 + 4;
  localparam int LIM16 = 4 * 16 + 8 + 4;

  int n_checks = 0;
  int n_fail   = 0;
  int q8[$];
  int q16[$];
  int lat_ref8[2] = '{-1, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int ref_isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int ref_icbrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int ref_y(input int a, input int b, input bit m);
    return m ? ref_icbrt(a + ref_isqrt(b)) : ref_isqrt(a + ref_icbrt(b));
  endfunction

  function automatic int pick8();
    int r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  // Monitors: pop one expectation per done pulse; done must never last two cycles.
  logic pd8 = 1'b0, pd16 = 1'b0;
  always @(negedge clk) begin
    if (done8) begin
      check("done8_width", pd8, 0);
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done8_spurious: done_o=1 with y=%0d but no request pending", y8);
      end else check("y8", y8, q8.pop_front());
    end
    pd8 = done8;
    if (done16) begin
      check("done16_width", pd16, 0);
      if (q16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done16_spurious: done_o=1 with y=%0d but no request pending", y16);
      end else check("y16", y16, q16.pop_front());
    end
    pd16 = done16;
  end

  // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle.
  task automatic op8(input int a, input int b, input bit m, input int req_y,
                     input int poke_mid, input bit poke_done);
    int lat;
    a8 = 8'(a); b8 = 8'(b); mode8 = m; start8 = 1'b1;
    q8.push_back(req_y);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start8 = (lat == poke_mid);
      a8 = 8'($urandom); b8 = 8'($urandom);
      mode8 = (lat == poke_mid) ? ~m : 1'($urandom);
      if (!done8) check("busy8_run", busy8, 1);
    end while (!done8 && lat < LIM8);
    start8 = 1'b0;
    if (!done8) begin
      n_checks++; n_fail++;
      $display("FAIL lat8_timeout: no done_o within %0d cycles, required one", LIM8);
      q8.delete();
    end else begin
      check("busy8_done", busy8, 0);
      check("lat8_bound", lat <= 4 * 8 + 8, 1);
      if (lat_ref8[m] < 0) lat_ref8[m] = lat;
      else check("lat8_fixed", lat, lat_ref8[m]);
      if (poke_done) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    if (poke_done) check("start_in_done_ignored", busy8, 0);
  endtask

  task automatic op16(input int a, input int b, input bit m, input int req_y, output int busy_cyc);
    int lat;
    a16 = 16'(a); b16 = 16'(b); mode16 = m; start16 = 1'b1;
    q16.push_back(req_y);
    lat = 0;
    busy_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom);
      if (busy16) busy_cyc++;
    end while (!done16 && lat < LIM16);
    if (!done16) begin
      n_checks++; n_fail++;
      $display("FAIL lat16_timeout: no done_o within %0d cycles, required one", LIM16);
      q16.delete();
    end else check("lat16_bound", lat <= 4 * 16 + 8, 1);
    @(negedge clk);
  endtask

  int tab0[6][3] = '{'{0, 0, 0}, '{12, 60, 3}, '{45, 64, 7},
                     '{255, 255, 16}, '{30, 255, 6}, '{1, 255, 2}};
  int tab1[3][3] = '{'{30, 36, 3}, '{255, 255, 6}, '{0, 0, 0}};

  initial begin
    int bc1, bc2, rl;
    repeat (3) @(negedge clk);
    check("rst8_busy", busy8, 0);
    check("rst8_done", done8, 0);
    check("rst8_y", y8, 0);
    check("rst16_busy", busy16, 0);
    check("rst16_done", done16, 0);
    check("rst16_y", y16, 0);
    rst8 = 1'b1; rst16 = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) op8(tab0[i][0], tab0[i][1], 1'b0, tab0[i][2], 0, (i == 2));
    for (int i = 0; i < 3; i++) op8(tab1[i][0], tab1[i][1], 1'b1, tab1[i][2], 0, 1'b0);

    // Second start mid-operation with different operands must be ignored.
    op8(45, 64, 1'b0, 7, 3, 1'b0);
    op8(30, 36, 1'b1, 3, 4, 1'b0);

    // Reset late in the operation (second root phase), then a clean restart.
    op8(255, 255, 1'b0, 16, 0, 1'b0);
    rl = (lat_ref8[0] > 3) ? lat_ref8[0] : 10;
    a8 = 8'd12; b8 = 8'd60; mode8 = 1'b0; start8 = 1'b1;
    q8.push_back(3);
    @(negedge clk);
    start8 = 1'b0;
    repeat (rl - 3) @(negedge clk);
    #2;
    rst8 = 1'b0;
    q8.delete();
    #1;
    check("abort_busy", busy8, 0);
    check("abort_y", y8, 0);
    check("abort_done", done8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done8, 0);
    end
    rst8 = 1'b1;
    @(negedge clk);
    op8(12, 60, 1'b0, 3, 0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      int a, b;
      bit m;
      a = pick8(); b = pick8(); m = 1'($urandom);
      op8(a, b, m, ref_y(a, b, m), 0, (i % 97 == 0));
    end

    op16(65535, 65535, 1'b0, 256, bc1);
    op16(0, 1, 1'b0, 1, bc2);
    check("busy16_equal", bc1, bc2);
    for (int i = 0; i < 200; i++) begin
      int a, b;
      bit m;
      a = $urandom_range(0, 65535); b = $urandom_range(0, 65535); m = 1'($urandom);
      if (i % 10 == 0) a = 65535;
      op16(a, b, m, ref_y(a, b, m), bc1);
      check("busy16_fixed", bc1, bc2);
    end

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q16_drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
